mem_responder: RTL and testbench

- Memory-side responder for the datapath's instruction and data request interface.
- Accepts the datapath's imem/dmem requests and serializes them onto one single-ported, fixed-latency RAM.
- Returns one-cycle ihit/dhit pulses with load data, and absorbs the datapath halt.
- Sits between the datapath and RAM in place of caches; this is the serving end of the datapath's request/hit handshake.

---
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Datapath <-> memory responder request/hit bundle.
// Requests are held by the datapath until the matching hit pulse.
interface mem_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic [31:0] dmemload;
  logic        dhit;
  logic        halt;
  logic        halted;

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
    input  imemload, ihit, dmemload, dhit, halted
  );

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
    output imemload, ihit, dmemload, dhit, halted
  );
endinterface

// File: rtl/mem_responder.sv
// Serializes datapath imem/dmem requests onto one fixed-latency RAM port.
// Latency: RAM_LAT access cycles plus one hit cycle; requests held by datapath (no queueing).
module mem_responder #(
  parameter int RAM_LAT = 2,
  parameter int ADDR_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  mem_responder_if.slave    dp,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload
);

  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] IACC   = 3'd1;
  localparam logic [2:0] DACC   = 3'd2;
  localparam logic [2:0] IRESP  = 3'd3;
  localparam logic [2:0] DRESP  = 3'd4;
  localparam logic [2:0] HALTED = 3'd5;

  localparam logic GNT_INSTR = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              wr_q;
  logic              last_grant;

  logic d_req;
  logic i_req;
  logic grant_data;
  logic in_acc;

  // Byte-offset bits and upper address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dp.imemaddr[31:ADDR_W+2], dp.imemaddr[1:0],
                              dp.dmemaddr[31:ADDR_W+2], dp.dmemaddr[1:0]};

  assign d_req      = dp.dmemREN | dp.dmemWEN;
  assign i_req      = dp.imemREN;
  // On a conflict the class that was not served last wins.
  assign grant_data = d_req & (~i_req | (last_grant == GNT_INSTR));
  assign in_acc     = (state == IACC) | (state == DACC);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      last_grant  <= GNT_INSTR;
      dp.imemload <= '0;
      dp.dmemload <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dp.halt) begin
            state <= HALTED;
          end else if (grant_data) begin
            addr_q <= dp.dmemaddr[ADDR_W+1:2];
            data_q <= dp.dmemstore;
            wr_q   <= dp.dmemWEN;
            cnt    <= CNT_W'(RAM_LAT - 1);
            state  <= DACC;
          end else if (i_req) begin
            addr_q <= dp.imemaddr[ADDR_W+1:2];
            wr_q   <= 1'b0;
            cnt    <= CNT_W'(RAM_LAT - 1);
            state  <= IACC;
          end
        end
        IACC: begin
          if (cnt == '0) begin
            dp.imemload <= ramload;
            state       <= IRESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DACC: begin
          if (cnt == '0) begin
            if (!wr_q) dp.dmemload <= ramload;
            state <= DRESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        IRESP: begin
          last_grant <= GNT_INSTR;
          state      <= IDLE;
        end
        DRESP: begin
          last_grant <= GNT_DATA;
          state      <= IDLE;
        end
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset drops them without waiting for a clock.
  assign ramREN    = in_acc & ~wr_q;
  assign ramWEN    = (state == DACC) & wr_q;
  assign ramaddr   = in_acc ? addr_q : '0;
  assign ramstore  = ramWEN ? data_q : '0;
  assign dp.ihit   = (state == IRESP);
  assign dp.dhit   = (state == DRESP);
  assign dp.halted = (state == HALTED);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with RAM_LAT=2, ADDR_W=16.
module tb_mem_responder;
  logic        CLK;
  logic        nRST;
  logic        ramREN;
  logic        ramWEN;
  logic [15:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;

  int tests;
  int fails;

  mem_responder_if dp ();

  mem_responder #(.RAM_LAT(2), .ADDR_W(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .dp       (dp),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  logic hit_seq [0:7];
  int   nh;

  initial begin
    tests = 0;
    fails = 0;
    dp.imemREN = 0; dp.imemaddr = 0; dp.dmemREN = 0; dp.dmemWEN = 0;
    dp.dmemaddr = 0; dp.dmemstore = 0; dp.halt = 0; ramload = 0;

    // Reset state
    do_reset();
    chk("rst_ihit", dp.ihit, 0);
    chk("rst_dhit", dp.dhit, 0);
    chk("rst_halted", dp.halted, 0);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_imemload", dp.imemload, 0);
    chk("rst_dmemload", dp.dmemload, 0);

    // Instruction fetch
    dp.imemREN = 1; dp.imemaddr = 32'h0000_0004; ramload = 32'h8C22_0000;
    tick();
    chk("if_c1_ren", ramREN, 1);
    chk("if_c1_addr", ramaddr, 1);
    chk("if_c1_ihit", dp.ihit, 0);
    tick();
    chk("if_c2_ren", ramREN, 1);
    chk("if_c2_addr", ramaddr, 1);
    tick();
    chk("if_ihit", dp.ihit, 1);
    chk("if_load", dp.imemload, 32'h8C22_0000);
    chk("if_c3_ren", ramREN, 0);
    dp.imemREN = 0;
    tick();
    chk("if_ihit_drop", dp.ihit, 0);
    chk("if_load_hold", dp.imemload, 32'h8C22_0000);

    // Data write
    dp.dmemWEN = 1; dp.dmemaddr = 32'h0000_0010; dp.dmemstore = 32'hDEAD_BEEF;
    ramload = 32'h1234_5678;
    tick();
    chk("wr_c1_wen", ramWEN, 1);
    chk("wr_c1_ren", ramREN, 0);
    chk("wr_c1_addr", ramaddr, 4);
    chk("wr_c1_store", ramstore, 32'hDEAD_BEEF);
    tick();
    chk("wr_c2_wen", ramWEN, 1);
    chk("wr_c2_store", ramstore, 32'hDEAD_BEEF);
    tick();
    chk("wr_dhit", dp.dhit, 1);
    chk("wr_c3_wen", ramWEN, 0);
    chk("wr_dmemload", dp.dmemload, 0);
    dp.dmemWEN = 0;
    tick();
    chk("wr_dhit_drop", dp.dhit, 0);

    // Simultaneous requests after reset: D, I, D, I
    do_reset();
    dp.imemREN = 1; dp.imemaddr = 32'h0000_0008;
    dp.dmemREN = 1; dp.dmemaddr = 32'h0000_0020;
    ramload = 32'hA5A5_0001;
    nh = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("arb_not_dual", {31'b0, dp.ihit & dp.dhit}, 0);
      if (dp.dhit) begin
        if (nh < 8) hit_seq[nh] = 1'b1;
        nh++;
      end else if (dp.ihit) begin
        if (nh < 8) hit_seq[nh] = 1'b0;
        nh++;
      end
    end
    dp.imemREN = 0; dp.dmemREN = 0;
    chk("arb_hits", nh, 4);
    chk("arb_0_D", {31'b0, hit_seq[0]}, 1);
    chk("arb_1_I", {31'b0, hit_seq[1]}, 0);
    chk("arb_2_D", {31'b0, hit_seq[2]}, 1);
    chk("arb_3_I", {31'b0, hit_seq[3]}, 0);
    chk("arb_dload", dp.dmemload, 32'hA5A5_0001);
    chk("arb_iload", dp.imemload, 32'hA5A5_0001);
    tick();

    // Halt mid-DACC, misaligned address
    dp.dmemREN = 1; dp.dmemaddr = 32'h0000_0007; ramload = 32'hCAFE_F00D;
    tick();
    chk("mis_addr", ramaddr, 1);
    chk("mis_ren", ramREN, 1);
    dp.halt = 1;
    tick();
    chk("hlt_acc_halted", dp.halted, 0);
    tick();
    chk("hlt_dhit", dp.dhit, 1);
    chk("mis_dload", dp.dmemload, 32'hCAFE_F00D);
    chk("hlt_resp_halted", dp.halted, 0);
    dp.dmemREN = 0;
    tick();
    chk("hlt_idle_halted", dp.halted, 0);
    chk("hlt_idle_dhit", dp.dhit, 0);
    tick();
    chk("hlt_halted", dp.halted, 1);
    dp.imemREN = 1; dp.imemaddr = 32'h0000_000C;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hlt_no_ihit", dp.ihit, 0);
      chk("hlt_no_ren", ramREN, 0);
      chk("hlt_stays", dp.halted, 1);
    end

    // Reset during IACC cycle 1, then full-latency fetch
    dp.halt = 0;
    ramload = 32'h1111_2222;
    do_reset();
    tick();
    chk("ra_pre_ren", ramREN, 1);
    #2;
    nRST = 0;
    #1;
    chk("ra_ren_drop", ramREN, 0);
    chk("ra_addr_drop", ramaddr, 0);
    chk("ra_ihit", dp.ihit, 0);
    chk("ra_halted", dp.halted, 0);
    tick();
    nRST = 1;
    tick();
    chk("ra_c1_ren", ramREN, 1);
    chk("ra_c1_addr", ramaddr, 3);
    tick();
    chk("ra_c2_ihit", dp.ihit, 0);
    tick();
    chk("ra_ihit_resp", dp.ihit, 1);
    chk("ra_iload", dp.imemload, 32'h1111_2222);
    dp.imemREN = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
